// File: rtl/io_bridge_m_if.sv
// Signal bundle between the M-stage pipeline, the io_bridge_m bridge and the IO devices.
// Bridge side uses modport slave; the pipeline/device side (or a bench) uses modport master.
interface io_bridge_m_if;
    // Pipeline side
    logic        io_wr;
    logic        io_rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  be_op;
    logic [2:0]  me_op;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    // Device side: dev_req is held high until the cycle after dev_ack (a one-cycle pulse) is seen.
    logic        dev_ack;
    logic [31:0] dev_rdata;
    logic        dev_req;
    logic        dev_we;
    logic [1:0]  dev_sel;
    logic [31:0] dev_addr;
    logic [3:0]  dev_be;
    logic [31:0] dev_wdata;
    logic        bus_err;
    logic [1:0]  dbg_state;

    modport slave (
        input  io_wr, io_rd, addr, wdata, be_op, me_op, dev_ack, dev_rdata,
        output stall, rdata, rdata_valid, dev_req, dev_we, dev_sel, dev_addr,
        output dev_be, dev_wdata, bus_err, dbg_state
    );

    modport master (
        output io_wr, io_rd, addr, wdata, be_op, me_op, dev_ack, dev_rdata,
        input  stall, rdata, rdata_valid, dev_req, dev_we, dev_sel, dev_addr,
        input  dev_be, dev_wdata, bus_err, dbg_state
    );
endinterface

// File: rtl/io_bridge_m.sv
// M-stage bridge to slow memory-mapped IO: latches one access, runs req/ack, stalls, extends loads.
// Defining IO_TIMEOUT_EN adds a REQ timeout that aborts the access and pulses bus_err.
module io_bridge_m #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input logic          clk,
    input logic          reset,
    io_bridge_m_if.slave bif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_timeout;
    logic        r_dev_req;
    logic        r_we;
    logic        r_is_rd;
    logic [31:0] r_addr;
    logic [2:0]  r_me_op;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_rdata_valid;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    if (TIMEOUT < 1 || TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout
        $error("io_bridge_m: TIMEOUT must be at least 1 and fit in TO_W bits");
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bif.io_wr || bif.io_rd) begin
                    w_accept = 1'b1;
                    w_next   = S_REQ;
                end
            end
            S_REQ: begin
                if (bif.dev_ack || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bif.wdata;
        case (bif.be_op)
            2'b01: w_be = 4'b1111;
            2'b10: begin
                w_be    = bif.addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bif.wdata[15:0]}};
            end
            2'b11: begin
                w_be    = 4'b0001 << bif.addr[1:0];
                w_wdata = {4{bif.wdata[7:0]}};
            end
            default: w_be = 4'b0000;
        endcase
    end

    // Lane selection uses the latched address, not the live M-stage address.
    always_comb begin
        w_byte = r_addr[1] ? (r_addr[0] ? bif.dev_rdata[31:24] : bif.dev_rdata[23:16])
                           : (r_addr[0] ? bif.dev_rdata[15:8]  : bif.dev_rdata[7:0]);
        w_half = r_addr[1] ? bif.dev_rdata[31:16] : bif.dev_rdata[15:0];
        case (r_me_op)
            3'b010:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b011:  w_ext = {24'h000000, w_byte};
            3'b100:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'h0000, w_half};
            default: w_ext = bif.dev_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_dev_req     <= 1'b0;
            r_we          <= 1'b0;
            r_is_rd       <= 1'b0;
            r_addr        <= '0;
            r_me_op       <= '0;
            r_be          <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_dev_req     <= (w_next == S_REQ);
            r_rdata_valid <= 1'b0;
            if (w_accept) begin
                r_addr  <= bif.addr;
                r_we    <= bif.io_wr;
                r_is_rd <= bif.io_rd & ~bif.io_wr;
                r_me_op <= bif.me_op;
                r_be    <= w_be;
                r_wdata <= w_wdata;
            end
            // An aborted read returns zero; an acknowledged read returns the extended word.
            if ((r_state == S_REQ) && (w_next == S_DONE) && r_is_rd) begin
                r_rdata_valid <= 1'b1;
                r_rdata       <= bif.dev_ack ? w_ext : 32'h0;
            end
        end
    end

`ifdef IO_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;
    logic            r_bus_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
            if (w_accept) begin
                r_to_cnt <= '0;
            end else if (r_state == S_REQ) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign w_timeout   = (r_state == S_REQ) && !bif.dev_ack && (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign bif.bus_err = r_bus_err;
`else
    assign w_timeout   = 1'b0;
    assign bif.bus_err = 1'b0;
`endif

    assign bif.stall       = !reset && (((r_state == S_IDLE) && (bif.io_wr || bif.io_rd)) ||
                                        (r_state == S_REQ));
    assign bif.dev_req     = r_dev_req;
    assign bif.dev_we      = r_we;
    assign bif.dev_sel     = r_addr[5:4];
    assign bif.dev_addr    = {r_addr[31:2], 2'b00};
    assign bif.dev_be      = r_be;
    assign bif.dev_wdata   = r_wdata;
    assign bif.rdata       = r_rdata;
    assign bif.rdata_valid = r_rdata_valid;
    assign bif.dbg_state   = r_state;

endmodule
